// File: rtl/poly_frame_stats.sv
// poly_frame_stats: frames the poly_fun result stream and reports
// per-frame sum, min, max and sample count over valid/ready.
module poly_frame_stats #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int ACC_WIDTH = 19,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0]     out_min,
  output logic [WIDTH-1:0]     out_max,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FRAME_LEN);

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [ACC_WIDTH-1:0] osum_q, osum_d;
  logic [WIDTH-1:0]     omin_q, omin_d;
  logic [WIDTH-1:0]     omax_q, omax_d;
  logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;

  logic                 take;
  logic                 close;
  logic [ACC_WIDTH-1:0] sext;
  logic [ACC_WIDTH-1:0] nsum;
  logic [CNT_WIDTH-1:0] ncnt;
  logic [WIDTH-1:0]     nmin;
  logic [WIDTH-1:0]     nmax;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = osum_q;
  assign out_min   = omin_q;
  assign out_max   = omax_q;
  assign out_count = ocnt_q;

  // Running values as they would look after accepting in_data now;
  // the first sample of a frame seeds both extremes.
  assign take = in_valid && in_ready;
  assign sext = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign nsum = sum_q + sext;
  assign ncnt = cnt_q + 1'b1;
  assign nmin = (cnt_q == '0 || $signed(in_data) < $signed(min_q))
              ? in_data : min_q;
  assign nmax = (cnt_q == '0 || $signed(in_data) > $signed(max_q))
              ? in_data : max_q;
  assign close = in_ready
              && ((take && ncnt == FULL)
               || (flush && (cnt_q != '0 || take)));

  // Next-state and result capture; a closing frame also clears the
  // accumulators so ACCUM restarts clean after the hand-off.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    osum_d  = osum_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      ACCUM: begin
        if (take) begin
          sum_d = nsum;
          cnt_d = ncnt;
          min_d = nmin;
          max_d = nmax;
        end
        if (close) begin
          state_d = HOLD;
          osum_d  = take ? nsum : sum_q;
          ocnt_d  = take ? ncnt : cnt_q;
          omin_d  = take ? nmin : min_q;
          omax_d  = take ? nmax : max_q;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      osum_q  <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
      osum_q  <= osum_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_poly_frame_stats.sv
// tb_poly_frame_stats: directed checks of framing, flush, backpressure,
// async reset and a poly_fun-style feed (y = 3x^2 + 2x + 4).
module tb_poly_frame_stats;

  localparam int W  = 16;
  localparam int FL = 4;
  localparam int AW = 19;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_valid;
  logic [W-1:0]  tb_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [W-1:0]  out_min;
  logic [W-1:0]  out_max;
  logic [CW-1:0] out_count;

  logic          use_pipe;
  logic          xv;
  int            x;
  logic [2:0]    pv;
  logic [W-1:0]  py0, py1, py2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in for poly_fun: three register stages, valid delayed alike.
  always @(posedge clk) begin
    pv  <= {pv[1:0], xv};
    py0 <= W'(3 * x * x + 2 * x + 4);
    py1 <= py0;
    py2 <= py1;
  end

  assign in_valid = use_pipe ? pv[2] : tb_valid;
  assign in_data  = use_pipe ? py2   : tb_data;

  poly_frame_stats #(
    .WIDTH(W), .FRAME_LEN(FL), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_min(out_min), .out_max(out_max),
    .out_count(out_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic res(input string tag, input int s, input int mn,
                     input int mx, input int c);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"}, 32'($signed(out_sum)), s);
    chk({tag, "_min"}, 32'($signed(out_min)), mn);
    chk({tag, "_max"}, 32'($signed(out_max)), mx);
    chk({tag, "_cnt"}, 32'(out_count), c);
  endtask

  task automatic send(input int v);
    tb_valid = 1'b1;
    tb_data  = W'(v);
    step();
  endtask

  initial begin
    rst = 1'b1; tb_valid = 0; tb_data = '0; flush = 0;
    out_ready = 1'b1; use_pipe = 0; xv = 0; x = 0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_sum", 32'($signed(out_sum)), 0);
    chk("rst_cnt", 32'(out_count), 0);
    step();
    rst = 1'b0;
    step();

    // full frame
    send(89); send(25); send(324); send(4);
    tb_valid = 0;
    res("full", 442, 4, 324, 4);
    chk("full_rdy", 32'(in_ready), 0);
    step();
    chk("full_drop", 32'(out_valid), 0);
    chk("full_rdy2", 32'(in_ready), 1);

    // extremes
    send(-32768); send(32767); send(-1); send(-1);
    tb_valid = 0;
    res("ext", -3, -32768, 32767, 4);
    step();

    // backpressure with a pending sample
    out_ready = 0;
    send(1); send(2); send(3); send(4);
    tb_valid = 1; tb_data = W'(7);
    for (int i = 0; i < 5; i++) begin
      res("bp", 10, 1, 4, 4);
      chk("bp_rdy", 32'(in_ready), 0);
      step();
    end
    out_ready = 1;
    step();
    chk("bp_xfer", 32'(out_valid), 0);
    chk("bp_rdy3", 32'(in_ready), 1);
    step();
    tb_valid = 0; flush = 1;
    step();
    flush = 0;
    res("bp_next", 7, 7, 7, 1);
    step();

    // partial flush
    send(89); send(25);
    tb_valid = 0; flush = 1;
    step();
    flush = 0;
    res("pf", 114, 25, 89, 2);
    step();
    flush = 1;
    step();
    chk("empty1", 32'(out_valid), 0);
    step();
    chk("empty2", 32'(out_valid), 0);
    flush = 0;
    send(89); send(25);
    flush = 1;
    send(10);
    tb_valid = 0; flush = 0;
    res("pf3", 124, 10, 89, 3);
    step();
    send(1); send(1); send(1);
    flush = 1;
    send(1);
    tb_valid = 0; flush = 0;
    res("fl_full", 4, 1, 1, 4);
    step();
    chk("fl_once", 32'(out_valid), 0);

    // async reset mid-frame
    send(5); send(6);
    tb_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_sum", 32'($signed(out_sum)), 0);
    chk("ar_max", 32'($signed(out_max)), 0);
    chk("ar_cnt", 32'(out_count), 0);
    chk("ar_rdy", 32'(in_ready), 1);
    #1 rst = 1'b0;
    step();
    send(1); send(2); send(3); send(4);
    tb_valid = 0;
    res("ar_next", 10, 1, 4, 4);
    step();

    // poly_fun-style feed
    use_pipe = 1;
    xv = 1; x = 5;  step();
    x = -3; step();
    x = 10; step();
    x = 0;  step();
    xv = 0;
    for (int i = 0; i < 12 && !out_valid; i++) step();
    res("pipe", 442, 4, 324, 4);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
